// File: rtl/reset_sequencer.sv
// Power-on / software reset sequencer: holds every reset domain for an init window,
// releases them in staggered order, then runs a saturating cycle counter with optional watchdog.
module reset_sequencer #(
    parameter int NUM_DOMAINS               = 4,
    parameter int INITIALIZATION_CYCLE      = 8,
    parameter int STAGGER_CYCLE             = 2,
    parameter int COUNTER_WIDTH             = 32,
    parameter int KANATA_CYCLE_DISPLACEMENT = -1,
    parameter int TIMEOUT_CYCLE             = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       rstOut,
    input  logic                       swResetReq,
    output logic [NUM_DOMAINS-1:0]     rstDomain,
    output logic                       allReleased,
    output logic [COUNTER_WIDTH-1:0]   cycle,
    output logic signed [COUNTER_WIDTH:0] kanataCycle,
    output logic                       timedOut
);

    localparam int INIT_W = (INITIALIZATION_CYCLE > 1) ? $clog2(INITIALIZATION_CYCLE) : 1;
    localparam int STAG_W = (STAGGER_CYCLE > 1) ? $clog2(STAGGER_CYCLE) : 1;
    localparam int REL_W  = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

    localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INITIALIZATION_CYCLE - 1);
    localparam logic [STAG_W-1:0] STAG_LAST = STAG_W'(STAGGER_CYCLE - 1);
    localparam logic [REL_W-1:0]  REL_LAST  = REL_W'(NUM_DOMAINS - 1);
    localparam logic [REL_W-1:0]  REL_FIRST = REL_W'(1);

    localparam bit ALL_AT_ONCE = (NUM_DOMAINS == 1) || (STAGGER_CYCLE == 0);
    localparam bit TMO_EN      = (TIMEOUT_CYCLE != 0);
    localparam logic [COUNTER_WIDTH:0] TMO_LAST = (COUNTER_WIDTH + 1)'(TIMEOUT_CYCLE - 1);
    localparam logic signed [COUNTER_WIDTH:0] KANATA_DISP =
        (COUNTER_WIDTH + 1)'(KANATA_CYCLE_DISPLACEMENT);

    typedef enum logic [1:0] {
        ST_ASSERT,
        ST_RELEASE,
        ST_RUN,
        ST_TIMEOUT
    } state_t;

    state_t                   stateQ;
    logic [NUM_DOMAINS-1:0]   rstDomainQ;
    logic                     allReleasedQ;
    logic [COUNTER_WIDTH-1:0] cycleQ;
    logic                     timedOutQ;
    logic [INIT_W-1:0]        initCntQ;
    logic [STAG_W-1:0]        stagCntQ;
    logic [REL_W-1:0]         relIdxQ;

    logic [COUNTER_WIDTH-1:0] cycleD;
    logic                     timeoutHitD;

    // The watchdog hit lands exactly on TIMEOUT_CYCLE; otherwise the counter saturates at all-ones.
    always_comb begin
        cycleD      = cycleQ;
        timeoutHitD = 1'b0;
        if (!rstOut) begin
            if (TMO_EN && ({1'b0, cycleQ} == TMO_LAST)) begin
                cycleD      = cycleQ + 1'b1;
                timeoutHitD = 1'b1;
            end else if (cycleQ != '1) begin
                cycleD = cycleQ + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ       <= ST_ASSERT;
            rstDomainQ   <= '1;
            allReleasedQ <= 1'b0;
            cycleQ       <= '0;
            timedOutQ    <= 1'b0;
            initCntQ     <= '0;
            stagCntQ     <= '0;
            relIdxQ      <= '0;
        end else if (swResetReq) begin
            // A software request outranks any release, increment or timeout on this edge.
            stateQ       <= ST_ASSERT;
            rstDomainQ   <= '1;
            allReleasedQ <= 1'b0;
            cycleQ       <= '0;
            timedOutQ    <= 1'b0;
            initCntQ     <= '0;
            stagCntQ     <= '0;
            relIdxQ      <= '0;
        end else begin
            case (stateQ)
                ST_ASSERT: begin
                    if (initCntQ == INIT_LAST) begin
                        initCntQ <= '0;
                        stagCntQ <= '0;
                        if (ALL_AT_ONCE) begin
                            rstDomainQ   <= '0;
                            allReleasedQ <= 1'b1;
                            stateQ       <= ST_RUN;
                        end else begin
                            rstDomainQ[0] <= 1'b0;
                            relIdxQ       <= REL_FIRST;
                            stateQ        <= ST_RELEASE;
                        end
                    end else begin
                        initCntQ <= initCntQ + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (stagCntQ == STAG_LAST) begin
                        stagCntQ <= '0;
                        if (relIdxQ == REL_LAST) begin
                            rstDomainQ   <= '0;
                            allReleasedQ <= 1'b1;
                            stateQ       <= ST_RUN;
                        end else begin
                            rstDomainQ[relIdxQ] <= 1'b0;
                            relIdxQ             <= relIdxQ + 1'b1;
                        end
                    end else begin
                        stagCntQ <= stagCntQ + 1'b1;
                    end
                end
                ST_RUN: begin
                    cycleQ <= cycleD;
                    if (timeoutHitD) begin
                        timedOutQ <= 1'b1;
                        stateQ    <= ST_TIMEOUT;
                    end
                end
                ST_TIMEOUT: begin
                    stateQ <= ST_TIMEOUT;
                end
                default: begin
                    stateQ <= ST_ASSERT;
                end
            endcase
        end
    end

    assign rstDomain   = rstDomainQ;
    assign allReleased = allReleasedQ;
    assign cycle       = cycleQ;
    assign timedOut    = timedOutQ;
    assign kanataCycle = $signed({1'b0, cycleQ}) - KANATA_DISP;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: four parameterisations share stimulus and are checked against
// an edge-count reference model (release times and counter values derived arithmetically).
module tb_reset_sequencer;

    localparam int INIT = 8;
    localparam int NDOM = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic rstOut;
    logic swResetReq;

    logic [3:0]         rdAct[4];
    logic               relAct[4];
    logic               tmoAct[4];
    logic [31:0]        cycW[3];
    logic [3:0]         cycN;
    logic signed [32:0] kanW[3];
    logic signed [4:0]  kanN;

    // Instance configuration: 0 defaults, 1 no stagger, 2 watchdog at 20, 3 four-bit counter.
    int     pStag[4] = '{2, 0, 2, 2};
    int     pTmo[4]  = '{0, 0, 20, 0};
    longint pMax[4]  = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 15};

    int     seqEdge[4];
    longint mCyc[4];
    bit     mTmo[4];

    int vectors = 0;
    int miscompares = 0;

    reset_sequencer dut0 (
        .clk(clk), .rst_n(rst_n), .rstOut(rstOut), .swResetReq(swResetReq),
        .rstDomain(rdAct[0]), .allReleased(relAct[0]), .cycle(cycW[0]),
        .kanataCycle(kanW[0]), .timedOut(tmoAct[0])
    );

    reset_sequencer #(.STAGGER_CYCLE(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .rstOut(rstOut), .swResetReq(swResetReq),
        .rstDomain(rdAct[1]), .allReleased(relAct[1]), .cycle(cycW[1]),
        .kanataCycle(kanW[1]), .timedOut(tmoAct[1])
    );

    reset_sequencer #(.TIMEOUT_CYCLE(20)) dut2 (
        .clk(clk), .rst_n(rst_n), .rstOut(rstOut), .swResetReq(swResetReq),
        .rstDomain(rdAct[2]), .allReleased(relAct[2]), .cycle(cycW[2]),
        .kanataCycle(kanW[2]), .timedOut(tmoAct[2])
    );

    reset_sequencer #(.COUNTER_WIDTH(4)) dut3 (
        .clk(clk), .rst_n(rst_n), .rstOut(rstOut), .swResetReq(swResetReq),
        .rstDomain(rdAct[3]), .allReleased(relAct[3]), .cycle(cycN),
        .kanataCycle(kanN), .timedOut(tmoAct[3])
    );

    function automatic longint actCycle(int k);
        if (k == 3) return longint'(cycN);
        return longint'(cycW[k]);
    endfunction

    function automatic logic [3:0] expDom(int k);
        logic [3:0] d;
        for (int i = 0; i < NDOM; i++) d[i] = (seqEdge[k] < INIT + i * pStag[k]);
        return d;
    endfunction

    function automatic bit expRel(int k);
        return seqEdge[k] >= INIT + (NDOM - 1) * pStag[k];
    endfunction

    function automatic logic signed [32:0] expKan(int k);
        return 33'(mCyc[k] + 1);
    endfunction

    task automatic modelReset();
        for (int k = 0; k < 4; k++) begin
            seqEdge[k] = 0;
            mCyc[k]    = 0;
            mTmo[k]    = 1'b0;
        end
    endtask

    task automatic modelEdge(input bit sw, input bit ro);
        bit was;
        for (int k = 0; k < 4; k++) begin
            if (sw) begin
                seqEdge[k] = 0;
                mCyc[k]    = 0;
                mTmo[k]    = 1'b0;
            end else begin
                was = expRel(k);
                if (seqEdge[k] < 1000000) seqEdge[k]++;
                if (was && !mTmo[k] && !ro) begin
                    if (pTmo[k] != 0 && mCyc[k] == pTmo[k] - 1) begin
                        mCyc[k] = pTmo[k];
                        mTmo[k] = 1'b1;
                    end else if (mCyc[k] < pMax[k]) begin
                        mCyc[k]++;
                    end
                end
            end
        end
    endtask

    task automatic tick(input bit ro, input bit sw);
        rstOut     = ro;
        swResetReq = sw;
        @(posedge clk);
        modelEdge(sw, ro);
        #1;
    endtask

    task automatic applyReset();
        rst_n      = 1'b0;
        rstOut     = 1'b0;
        swResetReq = 1'b0;
        modelReset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        applyReset();
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (rdAct[k] !== 4'hF || relAct[k] !== 1'b0 || actCycle(k) != 0 || tmoAct[k] !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL reset_state dut%0d: got dom=%b rel=%b cyc=%0d tmo=%b, expected dom=1111 rel=0 cyc=0 tmo=0",
                         k, rdAct[k], relAct[k], actCycle(k), tmoAct[k]);
            end
        end
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (kanW[k] !== 33'sd1) begin
                miscompares++;
                $display("[TB] FAIL reset_kanata dut%0d: got %0d expected 1", k, kanW[k]);
            end
        end
    endtask

    task automatic test_release();
        for (int e = 1; e <= 16; e++) begin
            tick(1'b0, 1'b0);
            for (int k = 0; k < 4; k++) begin
                vectors++;
                if (rdAct[k] !== expDom(k) || relAct[k] !== expRel(k)) begin
                    miscompares++;
                    $display("[TB] FAIL release dut%0d edge %0d: got dom=%b rel=%b, expected dom=%b rel=%b",
                             k, e, rdAct[k], relAct[k], expDom(k), expRel(k));
                end
                vectors++;
                if (actCycle(k) != mCyc[k]) begin
                    miscompares++;
                    $display("[TB] FAIL release_cycle dut%0d edge %0d: got %0d expected %0d", k, e, actCycle(k), mCyc[k]);
                end
            end
            vectors++;
            if (kanW[0] !== expKan(0)) begin
                miscompares++;
                $display("[TB] FAIL release_kanata edge %0d: got %0d expected %0d", e, kanW[0], expKan(0));
            end
        end
    endtask

    task automatic test_stall();
        for (int e = 0; e < 12; e++) begin
            tick((e >= 2 && e < 7), 1'b0);
            for (int k = 0; k < 4; k++) begin
                vectors++;
                if (actCycle(k) != mCyc[k]) begin
                    miscompares++;
                    $display("[TB] FAIL stall_cycle dut%0d step %0d: got %0d expected %0d", k, e, actCycle(k), mCyc[k]);
                end
            end
            vectors++;
            if (kanW[0] !== expKan(0)) begin
                miscompares++;
                $display("[TB] FAIL stall_kanata step %0d: got %0d expected %0d", e, kanW[0], expKan(0));
            end
        end
    endtask

    task automatic test_counting();
        for (int e = 0; e < 60; e++) begin
            tick(($urandom_range(0, 3) == 0), 1'b0);
            for (int k = 0; k < 4; k++) begin
                vectors++;
                if (actCycle(k) != mCyc[k] || tmoAct[k] !== mTmo[k] || rdAct[k] !== expDom(k)) begin
                    miscompares++;
                    $display("[TB] FAIL counting dut%0d step %0d: got cyc=%0d tmo=%b dom=%b, expected cyc=%0d tmo=%b dom=%b",
                             k, e, actCycle(k), tmoAct[k], rdAct[k], mCyc[k], mTmo[k], expDom(k));
                end
            end
        end
        vectors++;
        if (actCycle(2) != 20 || tmoAct[2] !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL timeout_final: got cyc=%0d tmo=%b, expected cyc=20 tmo=1", actCycle(2), tmoAct[2]);
        end
        vectors++;
        if (cycN !== 4'd15) begin
            miscompares++;
            $display("[TB] FAIL saturate_final: got %0d expected 15", cycN);
        end
    endtask

    task automatic test_sw_reset();
        applyReset();
        repeat (11) tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (rdAct[k] !== 4'hF || relAct[k] !== 1'b0 || actCycle(k) != 0 || tmoAct[k] !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL sw_reset dut%0d: got dom=%b rel=%b cyc=%0d tmo=%b, expected dom=1111 rel=0 cyc=0 tmo=0",
                         k, rdAct[k], relAct[k], actCycle(k), tmoAct[k]);
            end
        end
        for (int e = 1; e <= 16; e++) begin
            tick(1'b0, 1'b0);
            for (int k = 0; k < 4; k++) begin
                vectors++;
                if (rdAct[k] !== expDom(k) || relAct[k] !== expRel(k) || actCycle(k) != mCyc[k]) begin
                    miscompares++;
                    $display("[TB] FAIL sw_rerun dut%0d edge %0d: got dom=%b rel=%b cyc=%0d, expected dom=%b rel=%b cyc=%0d",
                             k, e, rdAct[k], relAct[k], actCycle(k), expDom(k), expRel(k), mCyc[k]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        for (int e = 0; e < 200; e++) begin
            tick(($urandom_range(0, 3) == 0), ($urandom_range(0, 40) == 0));
            for (int k = 0; k < 4; k++) begin
                vectors++;
                if (rdAct[k] !== expDom(k) || relAct[k] !== expRel(k) || actCycle(k) != mCyc[k] || tmoAct[k] !== mTmo[k]) begin
                    miscompares++;
                    $display("[TB] FAIL random dut%0d step %0d: got dom=%b rel=%b cyc=%0d tmo=%b, expected dom=%b rel=%b cyc=%0d tmo=%b",
                             k, e, rdAct[k], relAct[k], actCycle(k), tmoAct[k], expDom(k), expRel(k), mCyc[k], mTmo[k]);
                end
            end
            for (int k = 0; k < 3; k++) begin
                vectors++;
                if (kanW[k] !== expKan(k)) begin
                    miscompares++;
                    $display("[TB] FAIL random_kanata dut%0d step %0d: got %0d expected %0d", k, e, kanW[k], expKan(k));
                end
            end
        end
    endtask

    task automatic test_async_reset();
        repeat (20) tick(1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        modelReset();
        #1;
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (rdAct[k] !== 4'hF || relAct[k] !== 1'b0 || actCycle(k) != 0 || tmoAct[k] !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL async_reset dut%0d: got dom=%b rel=%b cyc=%0d tmo=%b, expected dom=1111 rel=0 cyc=0 tmo=0",
                         k, rdAct[k], relAct[k], actCycle(k), tmoAct[k]);
            end
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            tick(1'b0, 1'b0);
            for (int k = 0; k < 4; k++) begin
                vectors++;
                if (rdAct[k] !== expDom(k) || actCycle(k) != mCyc[k]) begin
                    miscompares++;
                    $display("[TB] FAIL post_async dut%0d edge %0d: got dom=%b cyc=%0d, expected dom=%b cyc=%0d",
                             k, e, rdAct[k], actCycle(k), expDom(k), mCyc[k]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_release();
        test_stall();
        test_counting();
        test_sw_reset();
        test_back_to_back();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Synthesizable, parametrised successor to the test-bench clock/reset generator. Holds a configurable number of reset domains asserted for an initialization window after power-on reset, then releases them one by one in a staggered order. After release it maintains a saturating core cycle counter, a Kanata-aligned cycle view and an optional watchdog timeout. It sits between the board/bench reset source and the core, memory and peripheral reset inputs, and also feeds the trace logger.

## Interface
- NUM_DOMAINS, 4: number of independent reset outputs (1–16).
- INITIALIZATION_CYCLE, 8: clock edges during which all domains stay asserted (≥1).
- STAGGER_CYCLE, 2: edges between consecutive domain releases (0 = release all together).
- COUNTER_WIDTH, 32: width of the cycle counter.
- KANATA_CYCLE_DISPLACEMENT, -1: offset subtracted from the cycle count to give the Kanata cycle.
- TIMEOUT_CYCLE, 0: watchdog limit on the cycle count (0 = disabled).
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low; deassertion is synchronized to clk externally.
- rstOut  in  1  core still in internal reset; counting is suppressed while high.
- swResetReq  in  1  single-cycle request to re-run the full reset sequence.
- rstDomain  out  NUM_DOMAINS  per-domain reset, active-high; bit 0 is released first.
- allReleased  out  1  every domain released; high in RUN and TIMEOUT.
- cycle  out  COUNTER_WIDTH  cycles counted in RUN with rstOut low; saturates at all-ones.
- kanataCycle  out  COUNTER_WIDTH+1 (signed)  cycle − KANATA_CYCLE_DISPLACEMENT; combinational from cycle.
- timedOut  out  1  sticky watchdog flag.

## Operation
- States:
  - ASSERT: all domains held in reset; initCnt counts edges.
  - RELEASE: domains released in staggered order; stagCnt counts between releases; relIdx points at the next domain.
  - RUN: normal operation; cycle counting.
  - TIMEOUT: terminal watchdog state.
- Reset (rst_n low), applied immediately:
  - state=ASSERT, rstDomain=all ones, allReleased=0, cycle=0, timedOut=0, initCnt=0, stagCnt=0, relIdx=0.
  - kanataCycle therefore reads −KANATA_CYCLE_DISPLACEMENT (1 with defaults).
- ASSERT:
  - initCnt increments on each edge.
  - On the edge where initCnt==INITIALIZATION_CYCLE−1, rstDomain[0] clears.
  - If NUM_DOMAINS==1 or STAGGER_CYCLE==0, all bits clear on that edge and the next state is RUN. Otherwise the next state is RELEASE with relIdx=1.
- RELEASE:
  - stagCnt counts 0..STAGGER_CYCLE−1.
  - When it wraps, rstDomain[relIdx] clears and relIdx increments.
  - When the last bit clears, state=RUN and allReleased=1 on the same edge.
- RUN:
  - cycle increments on each edge where rstOut==0. It holds when rstOut==1 and holds at its maximum value.
  - If TIMEOUT_CYCLE≠0 and the registered cycle value equals TIMEOUT_CYCLE−1 on an incrementing edge, cycle becomes TIMEOUT_CYCLE, timedOut=1 and state=TIMEOUT on that edge.
- TIMEOUT: cycle is frozen, domains stay released, timedOut stays high.
- swResetReq, sampled in any state:
  - On that edge: state=ASSERT, rstDomain=all ones, allReleased=0, cycle=0, timedOut=0, all counters cleared.
  - A request during ASSERT restarts the initialization window.
  - swResetReq takes priority over any release, increment or timeout event on the same edge.
- Arithmetic:
  - kanataCycle is the sign-extended cycle minus the sign-extended displacement. It is never truncated.

## Timing
- Edge numbering: edge 1 is the first rising edge with rst_n high.
- Domain i clears at edge INITIALIZATION_CYCLE + i·STAGGER_CYCLE.
- allReleased rises at edge INITIALIZATION_CYCLE + (NUM_DOMAINS−1)·STAGGER_CYCLE.
- The first cycle increment is possible one edge after allReleased rises.
- All outputs are registered except kanataCycle. There is no combinational path from inputs to outputs.
- swResetReq takes effect with 1-edge latency: rstDomain reads all ones after the sampling edge.

## Test plan
- Power-on, defaults, rstOut=0 → rstDomain bits clear at edges 8, 10, 12, 14; allReleased high from edge 14; cycle=1 after edge 15; kanataCycle=2 at that point.
- STAGGER_CYCLE=0, NUM_DOMAINS=4 → rstDomain goes 4'b1111→4'b0000 at edge 8; state goes directly to RUN.
- rstOut high for 5 edges during RUN → cycle holds for exactly those 5 edges, then resumes +1 per edge.
- TIMEOUT_CYCLE=20 → timedOut rises on the edge where cycle reaches 20; cycle stays at 20 afterwards; rstDomain stays 0.
- swResetReq pulse during RELEASE (after domain 1 released) → next edge rstDomain=4'b1111, cycle=0; the full sequence repeats from edge 1 of the new count.
- COUNTER_WIDTH=4 → cycle saturates at 15 and stays there.
- rst_n asserted mid-RUN → all outputs return to their reset values immediately, without a clock edge.
